// File: rtl/partial_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : partial_dispatch_pkg
// Brief    : Shared types and constants for the partial dispatch controller.
// Revision : 1.0 - initial release
// ============================================================================
package partial_dispatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } dispatch_state_e;

  typedef logic inst_id_t;

  localparam int         INST_COUNT     = 2;
  localparam logic [3:0] STATUS_TIMEOUT = 4'hF;

endpackage
`default_nettype wire

// File: rtl/partial_dispatch_timer.sv
`default_nettype none
// ============================================================================
// Module   : partial_dispatch_timer
// Brief    : Loadable down-counter; expired flags the last permitted cycle.
// Revision : 1.0 - initial release
// ============================================================================
module partial_dispatch_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CNT_W'(TIMEOUT);
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  // Asserted while the count is 1: this cycle's decrement reaches zero.
  assign o_expired = (r_count <= CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/partial_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : partial_dispatch_ctrl
// Brief    : Round-robin dispatcher for two test_partial_module instances with
//            ready timeout. Optional PARTIAL_DISPATCH_HEALTH_EN steers requests
//            away from an instance that has timed out.
// Revision : 1.0 - initial release
// ============================================================================
module partial_dispatch_ctrl
  import partial_dispatch_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int RES_W   = 16,
  parameter int STAT_W  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              sys_clk,
  input  logic              sys_reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_data,
  output logic [1:0]        inst_enable,
  output logic [DATA_W-1:0] inst_data_in,
  input  logic [1:0]        inst_ready,
  input  logic [RES_W-1:0]  inst_data_out0,
  input  logic [RES_W-1:0]  inst_data_out1,
  input  logic [STAT_W-1:0] inst_status0,
  input  logic [STAT_W-1:0] inst_status1,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_data,
  output logic [STAT_W-1:0] rsp_status,
  output logic              rsp_inst,
  output logic              rsp_timeout,
  output logic              busy
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_ISSUE = ST_ISSUE;
  localparam logic [1:0] S_WAIT  = ST_WAIT;
  localparam logic [1:0] S_RESP  = ST_RESP;

  logic [1:0]        r_state;
  inst_id_t          r_rr;
  inst_id_t          r_sel;
  inst_id_t          w_pick;
  logic [DATA_W-1:0] r_data;
  logic [RES_W-1:0]  r_rsp_data;
  logic [STAT_W-1:0] r_rsp_status;
  logic              r_rsp_timeout;

  logic              w_issue;
  logic              w_wait;
  logic              w_resp;
  logic              w_busy;
  logic              w_sel_ready;
  logic              w_expired;
  logic [RES_W-1:0]  w_sel_data;
  logic [STAT_W-1:0] w_sel_status;

  assign w_issue      = (r_state == S_ISSUE);
  assign w_wait       = (r_state == S_WAIT);
  assign w_resp       = (r_state == S_RESP);
  assign w_busy       = (r_state != S_IDLE);
  assign w_sel_ready  = inst_ready[r_sel];
  assign w_sel_data   = (r_sel == inst_id_t'(1)) ? inst_data_out1 : inst_data_out0;
  assign w_sel_status = (r_sel == inst_id_t'(1)) ? inst_status1   : inst_status0;

`ifdef PARTIAL_DISPATCH_HEALTH_EN
  logic [INST_COUNT-1:0] r_unhealthy;
  logic [INST_COUNT-1:0] w_unhealthy_set;

  assign w_pick          = (r_unhealthy[r_rr] && !r_unhealthy[~r_rr]) ? ~r_rr : r_rr;
  assign w_unhealthy_set = r_unhealthy | (INST_COUNT'(1) << r_sel);

  // Both instances failing means the flags carry no information; start over.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      r_unhealthy <= '0;
    end else if (w_wait && !w_sel_ready && w_expired) begin
      r_unhealthy <= (&w_unhealthy_set) ? '0 : w_unhealthy_set;
    end
  end
`else
  assign w_pick = r_rr;
`endif

  partial_dispatch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (sys_clk),
    .rst       (sys_reset),
    .i_load    (w_issue),
    .i_en      (w_wait && !w_sel_ready),
    .o_expired (w_expired)
  );

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      r_state       <= S_IDLE;
      r_rr          <= inst_id_t'(0);
      r_sel         <= inst_id_t'(0);
      r_data        <= '0;
      r_rsp_data    <= '0;
      r_rsp_status  <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_data  <= req_data;
            r_sel   <= w_pick;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_sel_ready) begin
            r_rsp_data    <= w_sel_data;
            r_rsp_status  <= w_sel_status;
            r_rsp_timeout <= 1'b0;
            r_state       <= S_RESP;
          end else if (w_expired) begin
            r_rsp_data    <= '0;
            r_rsp_status  <= STAT_W'(STATUS_TIMEOUT);
            r_rsp_timeout <= 1'b1;
            r_state       <= S_RESP;
          end
        end
        S_RESP: begin
          // Alternate away from whoever served, so a redirect is not repeated.
          if (rsp_ready) begin
            r_rr    <= ~r_sel;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < INST_COUNT; gi++) begin : g_enable
    assign inst_enable[gi] = w_issue && (r_sel == inst_id_t'(gi));
  end

  assign req_ready    = !w_busy;
  assign busy         = w_busy;
  assign inst_data_in = w_busy ? r_data : '0;
  assign rsp_valid    = w_resp;
  assign rsp_data     = r_rsp_data;
  assign rsp_status   = r_rsp_status;
  assign rsp_inst     = r_sel;
  assign rsp_timeout  = r_rsp_timeout;

endmodule
`default_nettype wire
